// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall unit with its own destination-tag pipeline (EX .. last result stage).
// Optional saturating stall counter and stall_cnt port enabled by defining FWD_STALL_CNT_EN.
module fwd_hazard_unit #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 2,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned SEL_W     = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic                       id_reg_write,
  input  logic                       id_is_load,
  input  logic [REG_AW-1:0]          id_dst,
  input  logic [NUM_SRC*REG_AW-1:0]  id_src,
  input  logic [NUM_SRC-1:0]         id_src_used,
  input  logic                       freeze,
  input  logic                       flush,
  output logic                       stall_id,
  output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel
`ifdef FWD_STALL_CNT_EN
  ,output logic [CNT_W-1:0]          stall_cnt
`endif
);

  // The last tracked stage is never a forwarding candidate, so only slots 0..DEPTH-2 are stored.
  localparam int unsigned NSLOT = DEPTH - 1;

  logic              slot_valid [NSLOT];
  logic              slot_rw    [NSLOT];
  logic              slot_ld    [NSLOT];
  logic [REG_AW-1:0] slot_dst   [NSLOT];

  logic [NUM_SRC*SEL_W-1:0] cand_sel;
  logic                     hazard;
  logic                     found;
  logic [REG_AW-1:0]        src;
  logic                     issue;

  always_comb begin
    cand_sel = '0;
    hazard   = 1'b0;
    found    = 1'b0;
    src      = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src   = id_src[i*REG_AW +: REG_AW];
      found = 1'b0;
      if (id_src_used[i] && src != '0) begin
        for (int unsigned j = 0; j < NSLOT; j++) begin
          if (!found && slot_valid[j] && slot_rw[j] && slot_dst[j] == src) begin
            found                        = 1'b1;
            cand_sel[i*SEL_W +: SEL_W]   = SEL_W'(j + 1);
            if (slot_ld[j] && (j + 1) < LOAD_READY)
              hazard = 1'b1;
          end
        end
      end
    end
  end

  assign stall_id = id_valid & ~flush & hazard;
  assign issue    = ~stall_id & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NSLOT; k++) begin
        slot_valid[k] <= 1'b0;
        slot_rw[k]    <= 1'b0;
        slot_ld[k]    <= 1'b0;
        slot_dst[k]   <= '0;
      end
      ex_fwd_sel <= '0;
    end else if (!freeze) begin
      for (int unsigned k = 1; k < NSLOT; k++) begin
        slot_valid[k] <= slot_valid[k-1];
        slot_rw[k]    <= slot_rw[k-1];
        slot_ld[k]    <= slot_ld[k-1];
        slot_dst[k]   <= slot_dst[k-1];
      end
      slot_valid[0] <= issue & id_valid;
      slot_rw[0]    <= issue & id_reg_write;
      slot_ld[0]    <= issue & id_is_load;
      slot_dst[0]   <= issue ? id_dst : '0;
      ex_fwd_sel    <= issue ? cand_sel : '0;
    end
  end

`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall_id && !freeze && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule
